bit_serializer: RTL and testbench
=================================

# bit_serializer

Parallel-to-serial front end for the Moore sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and presents them one bit per clock on `x`, which connects directly to the detector's `x` input. A `hold` input pauses the stream, and `x_valid` qualifies every emitted bit. Back-to-back words stream with no idle cycle between them.

## Interface
- `WIDTH`, default 8: word width; legal range ≥ 2.
- `MSB_FIRST`, default 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset; clears all state immediately when low.
- `din`  in  WIDTH  parallel word to serialize.
- `din_valid`  in  1  `din` is valid this cycle.
- `din_ready`  out  1  block accepts `din` at this rising edge.
- `hold`  in  1  freezes the stream while high.
- `x`  out  1  serial bit to the detector.
- `x_valid`  out  1  `x` carries a live data bit this cycle.
- `busy`  out  1  a word is being shifted (state SHIFT).

## Operation
- Registers:
  - `state` ∈ {IDLE, SHIFT}
  - shift register `sh[WIDTH-1:0]`
  - bit counter `cnt`, width clog2(WIDTH), counting 0..WIDTH-1
  - registered `x` and `x_valid`
- Reset (`reset`=0, asynchronous):
  - state=IDLE, sh=0, cnt=0, x=0, x_valid=0, busy=0.
  - `din_ready` is forced to 0 while reset is low.
- `din_ready` (combinational):
  - 1 when reset is high, hold=0, and either state=IDLE, or state=SHIFT with cnt=WIDTH-1.
  - 0 otherwise.
- Accept: a word is accepted when din_valid & din_ready are both high at a rising edge. On accept:
  - sh ← din, cnt ← 0, state ← SHIFT.
  - x ← first bit: din[WIDTH-1] if MSB_FIRST, else din[0].
  - x_valid ← 1.
- SHIFT with hold=0, cnt<WIDTH-1:
  - cnt ← cnt+1.
  - x ← next bit (sh shifted toward the output end).
  - x_valid ← 1.
- SHIFT with hold=0, cnt=WIDTH-1 (last bit is on `x` this cycle):
  - If a word is accepted at this edge, load it as above; state stays SHIFT and there is no gap.
  - Otherwise state ← IDLE, x_valid ← 0, and x ← 0.
- hold=1 in any state:
  - sh, cnt and state are frozen, and x keeps its value.
  - x_valid ← 0 at the next edge; it returns to 1 at the first edge after hold falls.
  - No word is accepted.
- IDLE with no accept: x=0, x_valid=0.
- `busy` = (state==SHIFT).
- Wrap-around:
  - cnt never exceeds WIDTH-1.
  - For non-power-of-two WIDTH, cnt must reset to 0 on load, never by natural overflow.
- `din` changing while din_ready=0 has no effect.

## Timing
- Latency: the bit sampled from `din` at accept edge E appears on `x` in the cycle after E, with x_valid=1.
- Word duration: WIDTH consecutive cycles of x_valid=1 when hold stays 0.
- Throughput: one bit per clock, with 100% utilization for back-to-back words.
- `din_ready` depends on state, cnt and hold only, never on din_valid. No combinational path runs from din_valid to din_ready.
- Hold: each high cycle of `hold` adds exactly one cycle to the word's duration.
- Reset mid-word: the word in flight is discarded with no partial output. After reset rises, the first accept is possible at the first rising edge.

## Test plan
- Reset values: hold reset low for 3 cycles with din_valid=1 → din_ready=0, x=0, x_valid=0, busy=0 throughout. After release, din_ready=1 in the next cycle.
- Single word, MSB_FIRST=1, WIDTH=8, din=8'b1011_0010 → x over 8 cycles = 1,0,1,1,0,0,1,0 with x_valid=1. Then x_valid=0, x=0, busy=0.
- Back-to-back: 8'hA5 then 8'h3C with din_valid held high → 16 consecutive x_valid=1 cycles. Sequence is 1010_0101_0011_1100, and din_ready pulses exactly at bit 7 of the first word.
- Hold mid-word: 8'hF0 with hold=1 for 2 cycles after the 3rd bit → x_valid=0 for 2 cycles with x held at 1. The bit sequence 1,1,1,1,0,0,0,0 is otherwise unchanged and the total span is 10 cycles.
- Reset mid-word: assert reset after 4 bits of 8'hFF → outputs clear asynchronously, and the remaining 4 bits are never emitted. The next word, 8'h01, emits 0000_0001.
- LSB-first: MSB_FIRST=0, din=8'h0B → x = 1,1,0,1,0,0,0,0. Connected to the sequence detector, the detector's `z` matches a golden model fed with the same bit stream.

Source files
------------

// File: rtl/bit_serializer_if.sv
// rtl/bit_serializer_if.sv - word-in / bit-out bundle for bit_serializer
//
// Purpose: groups the parallel word handshake, the hold control and the
// serial bit outputs of bit_serializer into one bundle.
// Signals:
//   din[WIDTH-1:0]  parallel word (master -> serializer)
//   din_valid       din is valid this cycle
//   din_ready       serializer accepts din at this rising edge
//   hold            freezes the bit stream while high
//   x               serial bit to the sequence detector
//   x_valid         x carries a live data bit this cycle
//   busy            a word is being shifted
interface bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             hold;
  logic             x;
  logic             x_valid;
  logic             busy;

  modport master (
    output din, din_valid, hold,
    input  din_ready, x, x_valid, busy
  );

  modport slave (
    input  din, din_valid, hold,
    output din_ready, x, x_valid, busy
  );
endinterface

// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - parallel-to-serial front end for the Moore sequence detector
//
// Purpose: accepts WIDTH-bit words over a valid/ready handshake and emits
// them one bit per clock on x, qualified by x_valid. Back-to-back words
// stream without an idle cycle; hold pauses the stream.
// Ports:
//   clk    single clock, rising edge
//   reset  asynchronous, active-low reset
//   bus    bit_serializer_if.slave (din/din_valid/din_ready, hold,
//          x/x_valid, busy)
// Parameters:
//   WIDTH      word width, >= 2
//   MSB_FIRST  1: bit WIDTH-1 goes out first, 0: bit 0 goes out first
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic            clk,
  input  logic            reset,
  bit_serializer_if.slave bus
);

  localparam int            CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] sh;
  logic [CW-1:0]    cnt;
  logic             x_q;
  logic             x_valid_q;
  logic             accept;
  logic             at_last;

  assign at_last = (state == SHIFT) && (cnt == LAST);

  // Ready looks only at registered state and hold, so there is no path
  // from din_valid back to din_ready. Forced low while in reset.
  assign bus.din_ready = reset && !bus.hold && ((state == IDLE) || at_last);
  assign accept        = bus.din_valid && bus.din_ready;

  assign bus.x       = x_q;
  assign bus.x_valid = x_valid_q;
  assign bus.busy    = (state == SHIFT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      sh        <= '0;
      cnt       <= '0;
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
    end else if (bus.hold) begin
      // Everything frozen; only the qualifier drops.
      x_valid_q <= 1'b0;
    end else if (accept) begin
      // Load also covers the last-bit cycle of the previous word, which is
      // what gives gap-free back-to-back streaming.
      state     <= SHIFT;
      sh        <= bus.din;
      cnt       <= '0;
      x_q       <= (MSB_FIRST != 0) ? bus.din[WIDTH-1] : bus.din[0];
      x_valid_q <= 1'b1;
    end else if (state == SHIFT) begin
      if (cnt != LAST) begin
        // x already shows the bit at the output end of sh, so the next bit
        // is the one adjacent to it; sh then moves one place toward x.
        cnt       <= cnt + 1'b1;
        x_q       <= (MSB_FIRST != 0) ? sh[WIDTH-2] : sh[1];
        sh        <= (MSB_FIRST != 0) ? {sh[WIDTH-2:0], 1'b0}
                                      : {1'b0, sh[WIDTH-1:1]};
        x_valid_q <= 1'b1;
      end else begin
        state     <= IDLE;
        cnt       <= '0;
        x_q       <= 1'b0;
        x_valid_q <= 1'b0;
      end
    end else begin
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// tb/tb_bit_serializer.sv - directed self-checking bench for bit_serializer
module tb_bit_serializer;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  bit_serializer_if #(.WIDTH(8)) bm ();
  bit_serializer_if #(.WIDTH(8)) bl ();

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
    .clk   (clk),
    .reset (reset),
    .bus   (bm)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
    .clk   (clk),
    .reset (reset),
    .bus   (bl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends one word on the MSB-first instance and checks all 8 bits against
  // the hand-written expected sequence (first bit in exp_bits[7]).
  task automatic run_word(input logic [7:0] d, input logic [7:0] exp_bits, input string tag);
    logic [7:0] e;
    e = exp_bits;
    bm.din       = d;
    bm.din_valid = 1'b1;
    chk({tag, "_ready"}, bm.din_ready, 1'b1);
    step();
    bm.din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk({tag, "_x"}, bm.x, e[7-i]);
      chk({tag, "_xv"}, bm.x_valid, 1'b1);
      chk({tag, "_busy"}, bm.busy, 1'b1);
      step();
    end
    chk({tag, "_end_xv"}, bm.x_valid, 1'b0);
    chk({tag, "_end_x"}, bm.x, 1'b0);
    chk({tag, "_end_busy"}, bm.busy, 1'b0);
  endtask

  initial begin
    logic [15:0] b2b;
    logic [7:0]  hold_bits;
    logic [7:0]  lsb_bits;
    int          span;

    n_vec = 0;
    n_err = 0;
    b2b       = 16'b1010_0101_0011_1100;
    hold_bits = 8'b1111_0000;
    lsb_bits  = 8'b1101_0000;

    reset        = 1'b0;
    bm.din       = 8'hFF;
    bm.din_valid = 1'b1;
    bm.hold      = 1'b0;
    bl.din       = 8'h00;
    bl.din_valid = 1'b0;
    bl.hold      = 1'b0;

    // Reset held for 3 cycles with din_valid high.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_ready", bm.din_ready, 1'b0);
      chk("rst_x", bm.x, 1'b0);
      chk("rst_xv", bm.x_valid, 1'b0);
      chk("rst_busy", bm.busy, 1'b0);
    end
    bm.din_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rel_ready", bm.din_ready, 1'b1);
    chk("rel_ready_l", bl.din_ready, 1'b1);

    // Single word.
    run_word(8'b1011_0010, 8'b1011_0010, "single");

    // Back-to-back A5 then 3C.
    bm.din       = 8'hA5;
    bm.din_valid = 1'b1;
    step();
    bm.din = 8'h3C;
    for (int i = 0; i < 16; i++) begin
      chk("b2b_x", bm.x, b2b[15-i]);
      chk("b2b_xv", bm.x_valid, 1'b1);
      chk("b2b_ready", bm.din_ready, (i == 7 || i == 15) ? 1'b1 : 1'b0);
      step();
      if (i == 7) bm.din_valid = 1'b0;
    end
    chk("b2b_end_xv", bm.x_valid, 1'b0);
    chk("b2b_end_busy", bm.busy, 1'b0);

    // Hold for 2 cycles after the 3rd bit of F0.
    bm.din       = 8'hF0;
    bm.din_valid = 1'b1;
    step();
    bm.din_valid = 1'b0;
    span = 0;
    for (int i = 0; i < 8; i++) begin
      chk("hold_x", bm.x, hold_bits[7-i]);
      chk("hold_xv", bm.x_valid, 1'b1);
      span++;
      if (i == 2) begin
        bm.hold = 1'b1;
        for (int h = 0; h < 2; h++) begin
          step();
          span++;
          chk("hold_frz_xv", bm.x_valid, 1'b0);
          chk("hold_frz_x", bm.x, 1'b1);
          chk("hold_frz_busy", bm.busy, 1'b1);
          chk("hold_frz_ready", bm.din_ready, 1'b0);
        end
        bm.hold = 1'b0;
      end
      step();
    end
    chk("hold_span", span, 10);
    chk("hold_end_xv", bm.x_valid, 1'b0);

    // Reset after 4 bits of FF.
    bm.din       = 8'hFF;
    bm.din_valid = 1'b1;
    step();
    bm.din_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("rmid_x", bm.x, 1'b1);
      chk("rmid_xv", bm.x_valid, 1'b1);
      if (i < 3) step();
    end
    #2;
    reset = 1'b0;
    #1;
    chk("rmid_async_x", bm.x, 1'b0);
    chk("rmid_async_xv", bm.x_valid, 1'b0);
    chk("rmid_async_busy", bm.busy, 1'b0);
    chk("rmid_async_ready", bm.din_ready, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rmid_hold_xv", bm.x_valid, 1'b0);
    end
    reset = 1'b1;
    #1;
    run_word(8'h01, 8'b0000_0001, "after_rst");

    // LSB-first instance.
    bl.din       = 8'h0B;
    bl.din_valid = 1'b1;
    chk("lsb_ready", bl.din_ready, 1'b1);
    step();
    bl.din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("lsb_x", bl.x, lsb_bits[7-i]);
      chk("lsb_xv", bl.x_valid, 1'b1);
      step();
    end
    chk("lsb_end_xv", bl.x_valid, 1'b0);
    chk("lsb_end_busy", bl.busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
